// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command master: command control codes and FSM states.
package spi_pkg;

  typedef enum logic [1:0] {
    CTRL_WR_ADDR = 2'b00,
    CTRL_WR_DATA = 2'b01,
    CTRL_RD_ADDR = 2'b10,
    CTRL_RD_DATA = 2'b11
  } ctrl_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_STOP    = 3'd5
  } state_e;

  // Phase counter must index both the command shift and the read turnaround wait.
  function automatic int cnt_width(input int cmd_bits, input int wait_cycles);
    int w;
    w = $clog2(cmd_bits);
    if ($clog2(wait_cycles) > w) w = $clog2(wait_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register for the SPI master: parallel load, MSB-first serial out, serial in,
// and the low OUT_W bits presented as parallel out.
module spi_shift_reg #(
  parameter int WIDTH = 10,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_sin,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_sout,
  output logic [OUT_W-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], i_sin};
    end
  end

  assign o_sout = r_data[WIDTH-1];
  assign o_data = r_data[OUT_W-1:0];

endmodule

// File: rtl/spi_master.sv
// SPI command master, one SPI bit per clk: sends a FRAME_WIDTH+2 bit command word and, for
// read-data commands, waits RD_WAIT cycles then captures FRAME_WIDTH bits from MISO.
//   state   | meaning
//   IDLE    | SS_n high, cmd_ready high, waiting for a command
//   START   | SS_n low, MOSI presents the read/write select bit
//   SHIFT   | command word driven on MOSI, MSB first
//   WAIT    | read turnaround, MOSI held low
//   CAPTURE | MISO shifted in, MSB first
//   STOP    | SS_n high for one cycle; rsp_valid on read-data frames
module spi_master
  import spi_pkg::*;
#(
  parameter int FRAME_WIDTH = 8,
  parameter int RD_WAIT     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [FRAME_WIDTH+1:0] cmd_data,
  output logic                   rsp_valid,
  output logic [FRAME_WIDTH-1:0] rsp_data,
  output logic                   busy,
  output logic                   SS_n,
  output logic                   MOSI,
  input  logic                   MISO
);

  localparam int CMD_W = FRAME_WIDTH + 2;
  localparam int CNT_W = cnt_width(CMD_W, RD_WAIT);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(FRAME_WIDTH - 1);

  state_e                 r_state;
  state_e                 w_state_next;
  ctrl_e                  r_ctrl;
  logic [CNT_W-1:0]       r_cnt;
  logic [FRAME_WIDTH-1:0] r_rsp_hold;

  logic                   w_accept;
  logic                   w_shift;
  logic                   w_sin;
  logic                   w_sout;
  logic                   w_cnt_last;
  logic                   w_rd_data;
  logic [FRAME_WIDTH-1:0] w_sr_data;

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_rd_data = (r_ctrl == CTRL_RD_DATA);

  always_comb begin
    w_cnt_last = 1'b1;
    case (r_state)
      ST_SHIFT:   w_cnt_last = (r_cnt == SHIFT_LAST);
      ST_WAIT:    w_cnt_last = (r_cnt == WAIT_LAST);
      ST_CAPTURE: w_cnt_last = (r_cnt == CAP_LAST);
      default:    w_cnt_last = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) w_state_next = ST_START;
      end
      ST_START: begin
        w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_cnt_last) begin
          if (!w_rd_data)        w_state_next = ST_STOP;
          else if (RD_WAIT == 0) w_state_next = ST_CAPTURE;
          else                   w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cnt_last) w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_cnt_last) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= CTRL_WR_ADDR;
      r_rsp_hold <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_ctrl <= ctrl_e'(cmd_data[CMD_W-1 -: 2]);
      if (rsp_valid) r_rsp_hold <= w_sr_data;
    end
  end

  // Counter restarts on every phase change and wraps at the end of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((w_state_next != r_state) || w_cnt_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The command shares one register with capture: it is fully shifted out before MISO shifts in.
  assign w_shift = (r_state == ST_SHIFT) || (r_state == ST_CAPTURE);
  assign w_sin   = (r_state == ST_CAPTURE) && MISO;

  spi_shift_reg #(
    .WIDTH (CMD_W),
    .OUT_W (FRAME_WIDTH)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_sin   (w_sin),
    .i_data  (cmd_data),
    .o_sout  (w_sout),
    .o_data  (w_sr_data)
  );

  // SS_n decodes straight from the state register so reset raises it without waiting for a clock.
  assign SS_n      = (r_state == ST_IDLE) || (r_state == ST_STOP);
  assign MOSI      = ((r_state == ST_START) || (r_state == ST_SHIFT)) && w_sout;
  assign rsp_valid = (r_state == ST_STOP) && w_rd_data;
  assign rsp_data  = rsp_valid ? w_sr_data : r_rsp_hold;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a driver queues expected frames, a monitor/slave compares
// each SS_n-low window and STOP cycle against a frame-level model of the command protocol.
module tb_spi_master;

  localparam int FW = 8;
  localparam int RW = 2;
  localparam int CW = FW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_data;
  logic          rsp_valid;
  logic [FW-1:0] rsp_data;
  logic          busy;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [CW-1:0] cmd;
    logic [FW-1:0] miso;
    int            gap;
  } frame_t;

  frame_t        exp_q[$];
  bit            in_frame  = 1'b0;
  bit            gap_known = 1'b0;
  logic [FW-1:0] last_rsp  = '0;

  spi_master #(
    .FRAME_WIDTH (FW),
    .RD_WAIT     (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame-level model of the protocol.
  function automatic bit is_rd_data(input logic [CW-1:0] cmd);
    return cmd[CW-1:CW-2] == 2'b11;
  endfunction

  function automatic int exp_low_len(input logic [CW-1:0] cmd);
    return is_rd_data(cmd) ? (1 + CW + RW + FW) : (1 + CW);
  endfunction

  function automatic int exp_ready_lat(input logic [CW-1:0] cmd);
    return exp_low_len(cmd) + 2;
  endfunction

  function automatic logic exp_mosi(input logic [CW-1:0] cmd, input int i);
    if (i == 0) return cmd[CW-1];
    if (i <= CW) return cmd[CW-i];
    return 1'b0;
  endfunction

  // Monitor and MISO slave.
  initial begin : monitor
    frame_t      cur;
    int          idx;
    int          hi_run;
    int          cap0;
    logic [63:0] gv;
    logic [63:0] ev;
    cur.cmd  = '0;
    cur.miso = '0;
    cur.gap  = -1;
    idx    = 0;
    hi_run = 0;
    gv     = '0;
    ev     = '0;
    cap0   = 1 + CW + RW;
    MISO   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        hi_run   = 0;
        last_rsp = '0;
        chk("rsp_valid_in_reset", rsp_valid, 0);
        chk("ss_n_in_reset", SS_n, 1);
        chk("rsp_data_in_reset", rsp_data, 0);
        MISO = 1'($urandom);
      end else if (!SS_n) begin
        if (!in_frame) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame actual=SS_n_low required=no_frame");
            cur.cmd  = '0;
            cur.miso = '0;
            cur.gap  = -1;
          end else begin
            cur = exp_q.pop_front();
            if (cur.gap >= 0) chk("ss_n_high_gap", hi_run, cur.gap);
          end
          in_frame = 1'b1;
          idx      = 0;
          gv       = '0;
          ev       = '0;
        end
        gv = {gv[62:0], MOSI};
        ev = {ev[62:0], exp_mosi(cur.cmd, idx)};
        chk("rsp_valid_in_frame", rsp_valid, 0);
        chk("rsp_data_hold_in_frame", rsp_data, last_rsp);
        if (is_rd_data(cur.cmd) && idx >= cap0 && idx < cap0 + FW)
          MISO = cur.miso[FW-1-(idx-cap0)];
        else
          MISO = 1'($urandom);
        idx++;
      end else begin
        if (in_frame) begin
          chk("ss_n_low_len", idx, exp_low_len(cur.cmd));
          chk("mosi_seq", gv, ev);
          chk("mosi_stop", MOSI, 0);
          chk("rsp_valid_stop", rsp_valid, is_rd_data(cur.cmd));
          if (is_rd_data(cur.cmd)) begin
            chk("rsp_data", rsp_data, cur.miso);
            last_rsp = cur.miso;
          end else begin
            chk("rsp_data_hold_stop", rsp_data, last_rsp);
          end
          in_frame = 1'b0;
          hi_run   = 0;
        end else begin
          chk("rsp_valid_idle", rsp_valid, 0);
          chk("mosi_idle", MOSI, 0);
          chk("rsp_data_hold_idle", rsp_data, last_rsp);
        end
        hi_run++;
        MISO = 1'($urandom);
      end
    end
  end

  // mode 0: valid dropped while busy; 1: random valid/data while busy; 2: data all-ones, valid held
  task automatic send(input logic [CW-1:0] cmd, input logic [FW-1:0] miso, input int idle,
                      input int mode);
    int     k;
    frame_t f;
    repeat (idle) begin
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!cmd_ready) begin
      failures++;
      $display("FAIL accept_timeout actual=cmd_ready_low required=cmd_ready_high");
      cmd_valid = 1'b0;
      return;
    end
    f.cmd  = cmd;
    f.miso = miso;
    f.gap  = gap_known ? 2 + idle : -1;
    exp_q.push_back(f);
    gap_known = 1'b1;
    @(posedge clk);
    #1;
    k = 1;
    while (!cmd_ready && k < 100) begin
      case (mode)
        1: begin
          cmd_valid = 1'($urandom);
          cmd_data  = CW'($urandom);
        end
        2: begin
          cmd_valid = 1'b1;
          cmd_data  = '1;
        end
        default: begin
          cmd_valid = 1'b0;
          cmd_data  = CW'($urandom);
        end
      endcase
      @(posedge clk);
      #1;
      k++;
    end
    cmd_valid = 1'b0;
    chk("ready_latency", k, exp_ready_lat(cmd));
  endtask

  initial begin : driver
    frame_t f;
    int     k;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ss_n", SS_n, 1);
    chk("reset_mosi", MOSI, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    send(10'b00_0000_0101, 8'h00, 0, 0);
    send(10'b11_0000_0000, 8'hA5, 2, 0);
    send(10'b01_0011_1100, 8'h00, 1, 0);
    send(10'b10_0000_0101, 8'h00, 0, 0);
    send(10'h155, 8'h00, 0, 2);
    send(10'b11_1111_1111, 8'h01, 0, 1);
    send(10'b11_0101_0101, 8'hFF, 3, 0);

    for (int i = 0; i < 40; i++) begin
      send(CW'($urandom), FW'($urandom_range(1, (1 << FW) - 1)), $urandom_range(0, 3),
           $urandom_range(0, 2));
    end
    send(10'b11_0000_0000, 8'h96, 0, 0);

    // Abort a read-data frame after four captured bits.
    cmd_valid = 1'b1;
    cmd_data  = 10'b11_0101_1010;
    f.cmd  = cmd_data;
    f.miso = 8'hC3;
    f.gap  = 2;
    exp_q.push_back(f);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (17) @(posedge clk);
    #3;
    chk("ss_n_low_before_reset", SS_n, 0);
    chk("busy_before_reset", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_ss_n_async", SS_n, 1);
    chk("abort_mosi", MOSI, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3;
    rst       = 1'b0;
    gap_known = 1'b0;
    #1;
    chk("ready_after_reset", cmd_ready, 1);
    send(10'b01_1110_0001, 8'h00, 0, 0);
    send(10'b11_0011_0011, 8'h5A, 0, 0);

    k = 0;
    while ((exp_q.size() != 0 || in_frame) && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("monitor_idle", in_frame, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter FRAME_WIDTH, default 8: data bits per frame; the command word is FRAME_WIDTH+2 bits.
REQ-002 Parameter RD_WAIT, default 2: clk cycles between the last command bit and the first MISO data bit of a read-data frame.
REQ-003 clk  input  1  single system clock; all logic samples on the rising edge; one SPI bit per clk cycle.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  a command word is offered.
REQ-006 cmd_ready  output  1  the block accepts a command this cycle; high only in IDLE.
REQ-007 cmd_data  input  FRAME_WIDTH+2  command word: [FW+1:FW] = ctrl, [FW-1:0] = addr/data.
REQ-008 rsp_valid  output  1  one-cycle pulse: rsp_data holds read data.
REQ-009 rsp_data  output  FRAME_WIDTH  byte captured from MISO, MSB first.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 SS_n  output  1  slave select, active-low.
REQ-012 MOSI  output  1  serial data to the slave.
REQ-013 MISO  input  1  serial data from the slave.

Function
REQ-014 Ctrl encodings SHALL be 00 write address, 01 write data, 10 read address, 11 read data.
REQ-015 States SHALL be IDLE, START, SHIFT, WAIT, CAPTURE and STOP.
REQ-016 A command SHALL be accepted only on cycle T with cmd_valid && cmd_ready; cmd_data is latched at T; IDLE -> START.
REQ-017 START (T+1) SHALL drive SS_n=0 and MOSI=cmd[FW+1] as the read/write select bit.
REQ-018 SHIFT SHALL drive MOSI = cmd[FW+1], cmd[FW], ..., cmd[0], one bit per cycle, over cycles T+2 .. T+FW+3 (10 cycles at FW=8).
REQ-019 After SHIFT, ctrl != 11 SHALL go to STOP; ctrl == 11 SHALL go to WAIT.
REQ-020 WAIT SHALL last RD_WAIT cycles with SS_n=0 and MOSI=0; RD_WAIT=0 SHALL skip WAIT and go straight to CAPTURE.
REQ-021 CAPTURE SHALL sample MISO on FW consecutive rising edges, shift it in MSB first, then go to STOP.
REQ-022 STOP SHALL last exactly one cycle with SS_n=1 and MOSI=0, then go to IDLE, giving a minimum SS_n-high gap of 2 cycles between frames.
REQ-023 rsp_valid SHALL pulse for exactly the STOP cycle of a read-data frame; rsp_data SHALL hold its value until the next capture completes.
REQ-024 In IDLE, SS_n SHALL be 1 and MOSI 0.
REQ-025 cmd_valid outside IDLE SHALL be ignored; cmd_data changes after acceptance SHALL not affect the frame in flight.
REQ-026 A bit counter of ceil(log2(FW+2)) bits SHALL count modulo the active phase length and clear on every state change.
REQ-027 Frame length in cycles SHALL be FW+4 for write/read-address frames and FW+4+RD_WAIT+FW for read-data frames, both START through STOP inclusive.

Reset
REQ-028 Reset values: SS_n=1, MOSI=0, cmd_ready=1 (state IDLE), busy=0, rsp_valid=0, rsp_data=0, counter=0.
REQ-029 Reset asserted mid-frame SHALL force SS_n high immediately and asynchronously, abort the frame with no rsp_valid, and drop the latched command.
REQ-030 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-031 Package spi_pkg SHALL hold the ctrl encodings (CTRL_WR_ADDR, CTRL_WR_DATA, CTRL_RD_ADDR, CTRL_RD_DATA) and the state enumeration.
REQ-032 A single sub-module, spi_shift_reg (parallel load, serial out MSB-first, serial in, parallel out), is natural; the FSM and counter remain in spi_master.

Verification
REQ-033 Write address: cmd_data=10'b00_0000_0101 -> SS_n low for 11 cycles, MOSI = 0,0,0,0,0,0,0,0,1,0,1, no rsp_valid, cmd_ready high again 13 cycles after acceptance.
REQ-034 Read data, RD_WAIT=2: cmd_data=10'b11_0000_0000 with MISO driven 8'hA5 MSB first, starting 2 cycles after the last command bit -> rsp_data=8'hA5 and a one-cycle rsp_valid in STOP.
REQ-035 Back-to-back: cmd_valid held high with write data 8'h3C then read address 8'h05 -> second frame's SS_n falls exactly 2 cycles after the first frame's SS_n rises.
REQ-036 Reset in CAPTURE after 4 bits -> SS_n=1 immediately, rsp_valid never pulses, rsp_data=0, cmd_ready=1 after release.
REQ-037 cmd_data toggled to 10'h3FF on every cycle after acceptance of 10'h155 -> MOSI sequence still matches 10'h155.
